game_menu_select: RTL and testbench

Generalised N-option menu controller for the VGA game shell. It tracks a cursor across NUM_OPTIONS entries, using edge-detected up/down/confirm/back buttons sampled once per frame. After a post-entry lockout it raises a start request and holds it until the game FSM acknowledges. It also produces the registered menu pixel colour and 7-segment mode readout. It sits between the text renderers (per-option hit bits) and the top-level game-state controller.

---
 rtl/game_menu_select.sv | 176 +++++++++++++++++
 tb/tb_game_menu_select.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/game_menu_select.sv
// game_menu_select: N-option menu controller for the VGA game shell.
// Moves a cursor with frame-sampled buttons, issues a start request and
// holds it until it is acknowledged, and drives the menu pixel colour and
// the 7-segment mode readout.
module game_menu_select #(
    parameter int unsigned NUM_OPTIONS    = 4,
    parameter int unsigned LOCKOUT_FRAMES = 30,
    parameter bit          WRAP           = 1'b1,
    parameter int unsigned DEFAULT_IDX    = 0,
    parameter logic [7:0]  TITLE_COLOR    = 8'b000_011_11,
    parameter logic [7:0]  OPT_COLOR      = 8'b010_010_01,
    parameter logic [7:0]  SEL_COLOR      = 8'b111_000_00,
    parameter logic [7:0]  CONF_COLOR     = 8'b000_111_00,
    parameter logic [7:0]  BG_COLOR       = 8'b111_111_11,
    localparam int unsigned IDX_W         = (NUM_OPTIONS > 1) ? $clog2(NUM_OPTIONS) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   frame_tick,
    input  logic [3:0]             btn,
    input  logic                   menu_reopen,
    input  logic                   title_hit,
    input  logic [NUM_OPTIONS-1:0] option_hit,
    input  logic                   start_ack,
    output logic [7:0]             pixel_color,
    output logic [IDX_W-1:0]       sel_idx,
    output logic                   start_req,
    output logic                   mode_locked,
    output logic [6:0]             hexout,
    output logic [6:0]             hexout2
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOCKOUT_FRAMES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPTIONS - 1);
    localparam logic [IDX_W-1:0] DEF_IDX  = IDX_W'(DEFAULT_IDX);
    localparam logic [6:0]       SEG_P    = 7'b0001100;
    localparam logic [6:0]       SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        S_LOCKOUT = 2'd0,
        S_BROWSE  = 2'd1,
        S_REQ     = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] sel_nxt;
    logic [3:0]       btn_prev;
    logic [3:0]       press;
    logic             up_p, down_p, conf_p, back_p;

    // Active-low 7-segment pattern for the decimal digits 1..9.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd1:    seg_digit = 7'b1111001;
            4'd2:    seg_digit = 7'b0100100;
            4'd3:    seg_digit = 7'b0110000;
            4'd4:    seg_digit = 7'b0011001;
            4'd5:    seg_digit = 7'b0010010;
            4'd6:    seg_digit = 7'b0000010;
            4'd7:    seg_digit = 7'b1111000;
            4'd8:    seg_digit = 7'b0000000;
            4'd9:    seg_digit = 7'b0010000;
            default: seg_digit = 7'b1111111;
        endcase
    endfunction

    // Rising-edge detect of the buttons, evaluated only on frame ticks.
    always_comb begin
        press  = frame_tick ? (btn & ~btn_prev) : 4'b0000;
        up_p   = press[0];
        down_p = press[1];
        conf_p = press[2];
        back_p = press[3];
    end

    // Next-state, lockout counter and cursor computation.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_idx;
        if (menu_reopen) begin
            state_nxt = S_LOCKOUT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_LOCKOUT: begin
                    if (frame_tick) begin
                        if (cnt == LAST_CNT) begin
                            state_nxt = S_BROWSE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                S_BROWSE: begin
                    if (conf_p) begin
                        state_nxt = S_REQ;
                    end else if (up_p && !down_p) begin
                        if (sel_idx == '0)
                            sel_nxt = WRAP ? LAST_IDX : sel_idx;
                        else
                            sel_nxt = sel_idx - IDX_W'(1);
                    end else if (down_p && !up_p) begin
                        if (sel_idx == LAST_IDX)
                            sel_nxt = WRAP ? '0 : sel_idx;
                        else
                            sel_nxt = sel_idx + IDX_W'(1);
                    end
                end
                S_REQ: begin
                    // Acknowledge takes priority over a same-cycle back press.
                    if (start_ack)
                        state_nxt = S_LOCKED;
                    else if (back_p)
                        state_nxt = S_BROWSE;
                end
                default: ;
            endcase
        end
    end

    // Menu state registers; status and readouts are registered from next-state values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_LOCKOUT;
            cnt         <= '0;
            sel_idx     <= DEF_IDX;
            btn_prev    <= 4'b0000;
            start_req   <= 1'b0;
            mode_locked <= 1'b0;
            hexout      <= seg_digit(4'(DEF_IDX) + 4'd1);
            hexout2     <= SEG_DASH;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sel_idx     <= sel_nxt;
            if (frame_tick)
                btn_prev <= btn;
            start_req   <= (state_nxt == S_REQ);
            mode_locked <= (state_nxt == S_REQ) || (state_nxt == S_LOCKED);
            hexout      <= seg_digit(4'(sel_nxt) + 4'd1);
            hexout2     <= (state_nxt == S_LOCKOUT) ? SEG_DASH : SEG_P;
        end
    end

    logic [NUM_OPTIONS-1:0] sel_mask;
    logic                   hit_sel, hit_other;
    logic [7:0]             pix_nxt;

    // Prioritised colour lookup for the current pixel.
    always_comb begin
        sel_mask  = NUM_OPTIONS'(1) << sel_idx;
        hit_sel   = |(option_hit & sel_mask);
        hit_other = |(option_hit & ~sel_mask);
        pix_nxt   = BG_COLOR;
        if (title_hit)
            pix_nxt = TITLE_COLOR;
        else if (hit_sel)
            pix_nxt = ((state == S_REQ) || (state == S_LOCKED)) ? CONF_COLOR : SEL_COLOR;
        else if (hit_other)
            pix_nxt = OPT_COLOR;
    end

    // One-clock pixel colour register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pixel_color <= BG_COLOR;
        else
            pixel_color <= pix_nxt;
    end

endmodule

// File: tb/tb_game_menu_select.sv
// Directed bench for game_menu_select: a wrapping and a saturating instance
// share one stimulus stream.
module tb_game_menu_select;

    localparam logic [7:0] TITLE_C = 8'b000_011_11;
    localparam logic [7:0] OPT_C   = 8'b010_010_01;
    localparam logic [7:0] SEL_C   = 8'b111_000_00;
    localparam logic [7:0] CONF_C  = 8'b000_111_00;
    localparam logic [7:0] BG_C    = 8'b111_111_11;
    localparam logic [6:0] D1      = 7'b1111001;
    localparam logic [6:0] D4      = 7'b0011001;
    localparam logic [6:0] LP      = 7'b0001100;
    localparam logic [6:0] DASH    = 7'b0111111;

    logic       clock;
    logic       reset_n;
    logic       frame_tick;
    logic [3:0] btn;
    logic       menu_reopen;
    logic       title_hit;
    logic [3:0] option_hit;
    logic       start_ack;

    logic [7:0] w_pix, s_pix;
    logic [1:0] w_sel, s_sel;
    logic       w_req, s_req, w_lock, s_lock;
    logic [6:0] w_hex, s_hex, w_hex2, s_hex2;

    int vectors = 0;
    int errors  = 0;

    game_menu_select #(.NUM_OPTIONS(4), .LOCKOUT_FRAMES(30), .WRAP(1'b1)) dut_wrap (
        .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .btn(btn),
        .menu_reopen(menu_reopen), .title_hit(title_hit), .option_hit(option_hit),
        .start_ack(start_ack), .pixel_color(w_pix), .sel_idx(w_sel),
        .start_req(w_req), .mode_locked(w_lock), .hexout(w_hex), .hexout2(w_hex2)
    );

    game_menu_select #(.NUM_OPTIONS(4), .LOCKOUT_FRAMES(30), .WRAP(1'b0)) dut_sat (
        .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .btn(btn),
        .menu_reopen(menu_reopen), .title_hit(title_hit), .option_hit(option_hit),
        .start_ack(start_ack), .pixel_color(s_pix), .sel_idx(s_sel),
        .start_req(s_req), .mode_locked(s_lock), .hexout(s_hex), .hexout2(s_hex2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame tick with the given button levels; btn stays at that level.
    task automatic frame(input logic [3:0] b);
        btn        = b;
        frame_tick = 1'b1;
        @(posedge clock);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        frame_tick  = 1'b0;
        btn         = 4'b0100;
        menu_reopen = 1'b0;
        title_hit   = 1'b0;
        option_hit  = 4'b0000;
        start_ack   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_sel", 32'(w_sel), 32'd0);
        chk("rst_req", 32'(w_req), 32'd0);
        chk("rst_lock", 32'(w_lock), 32'd0);
        chk("rst_pix", 32'(w_pix), 32'(BG_C));
        chk("rst_hex", 32'(w_hex), 32'(D1));
        chk("rst_hex2", 32'(w_hex2), 32'(DASH));
        reset_n = 1'b1;

        // Confirm held from reset: 29 frames still locked out, 30th enters browse.
        repeat (29) frame(4'b0100);
        chk("lockout29_hex2", 32'(w_hex2), 32'(DASH));
        frame(4'b0100);
        chk("lockout30_hex2", 32'(w_hex2), 32'(LP));
        repeat (10) frame(4'b0100);
        chk("held_conf_req", 32'(w_req), 32'd0);
        repeat (4) frame(4'b0000);
        frame(4'b0100);
        chk("conf_req", 32'(w_req), 32'd1);
        chk("conf_sel", 32'(w_sel), 32'd0);
        chk("conf_lock", 32'(w_lock), 32'd1);

        // Back out of the request.
        frame(4'b1000);
        chk("back_req", 32'(w_req), 32'd0);
        chk("back_lock", 32'(w_lock), 32'd0);
        frame(4'b0000);

        // Up at index 0: wrap goes to 3, saturate stays at 0.
        frame(4'b0001);
        chk("up_wrap_sel", 32'(w_sel), 32'd3);
        chk("up_wrap_hex", 32'(w_hex), 32'(D4));
        chk("up_sat_sel", 32'(s_sel), 32'd0);
        frame(4'b0000);
        frame(4'b0010);
        chk("down_wrap_sel", 32'(w_sel), 32'd0);
        chk("down_wrap_hex", 32'(w_hex), 32'(D1));
        chk("down_sat_sel", 32'(s_sel), 32'd1);
        frame(4'b0000);
        repeat (4) begin
            frame(4'b0010);
            frame(4'b0000);
        end
        chk("down5_sat_sel", 32'(s_sel), 32'd3);
        chk("down5_sat_hex", 32'(s_hex), 32'(D4));
        chk("down5_wrap_sel", 32'(w_sel), 32'd0);

        // Up and down together: no move.
        frame(4'b0011);
        chk("updown_wrap_sel", 32'(w_sel), 32'd0);
        chk("updown_sat_sel", 32'(s_sel), 32'd3);
        frame(4'b0000);

        // Cursor highlight while browsing.
        option_hit = 4'b0001;
        clk1();
        chk("pix_browse_sel", 32'(w_pix), 32'(SEL_C));
        chk("pix_browse_other", 32'(s_pix), 32'(OPT_C));
        option_hit = 4'b0000;

        // Confirm together with up: request, cursor does not move.
        frame(4'b0101);
        chk("confup_req", 32'(w_req), 32'd1);
        chk("confup_sel", 32'(w_sel), 32'd0);
        frame(4'b0000);

        // Ack coincident with back: ack wins, locked.
        start_ack = 1'b1;
        frame(4'b1000);
        start_ack = 1'b0;
        chk("ack_req", 32'(w_req), 32'd0);
        chk("ack_lock", 32'(w_lock), 32'd1);
        frame(4'b0000);
        chk("locked_stay", 32'(w_lock), 32'd1);

        // Pixel path in the locked state.
        title_hit  = 1'b1;
        option_hit = 4'b0001;
        clk1();
        chk("pix_title", 32'(w_pix), 32'(TITLE_C));
        title_hit = 1'b0;
        clk1();
        chk("pix_conf", 32'(w_pix), 32'(CONF_C));
        chk("pix_sat_opt", 32'(s_pix), 32'(OPT_C));
        option_hit = 4'b0000;
        clk1();
        chk("pix_bg", 32'(w_pix), 32'(BG_C));

        // Reopen: back to lockout, cursor retained.
        menu_reopen = 1'b1;
        clk1();
        menu_reopen = 1'b0;
        chk("reopen_hex2", 32'(w_hex2), 32'(DASH));
        chk("reopen_lock", 32'(w_lock), 32'd0);
        chk("reopen_sat_sel", 32'(s_sel), 32'd3);
        chk("reopen_sat_hex", 32'(s_hex), 32'(D4));

        // Up press inside lockout is ignored, the same press afterwards is taken.
        repeat (10) frame(4'b0000);
        frame(4'b0001);
        frame(4'b0000);
        repeat (17) frame(4'b0000);
        chk("relock29_hex2", 32'(w_hex2), 32'(DASH));
        chk("relock_ign_sel", 32'(w_sel), 32'd0);
        frame(4'b0000);
        chk("relock30_hex2", 32'(w_hex2), 32'(LP));
        frame(4'b0001);
        chk("after_lock_wrap_sel", 32'(w_sel), 32'd3);
        chk("after_lock_sat_sel", 32'(s_sel), 32'd2);
        frame(4'b0000);

        // Async reset in the middle of a line.
        title_hit = 1'b1;
        clk1();
        chk("pre_rst_pix", 32'(w_pix), 32'(TITLE_C));
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pix", 32'(w_pix), 32'(BG_C));
        chk("async_rst_sel", 32'(w_sel), 32'd0);
        chk("async_rst_hex2", 32'(w_hex2), 32'(DASH));
        title_hit = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
